// File: rtl/ternary_word_packer_if.sv
// Chunk-in / word-out bus of the ternary word packer.
// The slave side is the packer; the master side drives chunks and consumes words.
interface ternary_word_packer_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_W     = $clog2(OUT_WIDTH / IN_WIDTH + 1)
);
  logic [IN_WIDTH-1:0]  data;
  logic                 valid;
  logic                 flush;
  logic [OUT_WIDTH-1:0] word;
  logic [CNT_W-1:0]     bytes;
  logic                 word_valid;
  logic                 ready;

  modport master (
    output data, valid, flush, ready,
    input  word, bytes, word_valid
  );

  modport slave (
    input  data, valid, flush, ready,
    output word, bytes, word_valid
  );
endinterface

// File: rtl/ternary_word_packer.sv
// Packs IN_WIDTH-bit ternary chunks little-endian into OUT_WIDTH-bit words and
// queues them in a small registered FIFO; a word that finds the FIFO full is dropped and flagged.
module ternary_word_packer #(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  ternary_word_packer_if.slave  bus,
  output logic                  overflow_o,
  output logic                  busy_o
);
  localparam int LANES = OUT_WIDTH / IN_WIDTH;
  localparam int CNT_W = $clog2(LANES + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0]     lane_cnt;
  logic [OUT_WIDTH-1:0] asm_q;
  logic [CNT_W-1:0]     cnt_next;
  logic [OUT_WIDTH-1:0] asm_next;
  logic                 push;

  logic [OUT_WIDTH-1:0] mem_word [FIFO_DEPTH];
  logic [CNT_W-1:0]     mem_bytes [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [OCC_W-1:0]     occ;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 do_push;

  always_comb begin
    asm_next = asm_q;
    for (int l = 0; l < LANES; l++) begin
      if (bus.valid && (lane_cnt == CNT_W'(l))) begin
        asm_next[l*IN_WIDTH +: IN_WIDTH] = bus.data;
      end
    end
    cnt_next = lane_cnt + CNT_W'(bus.valid);
    // A completing byte plus flush yields only the full word, never an extra empty one.
    push = (cnt_next == CNT_W'(LANES)) || (bus.flush && (cnt_next != '0));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_cnt <= '0;
      asm_q    <= '0;
    end else if (clear_i) begin
      lane_cnt <= '0;
      asm_q    <= '0;
    end else if (push) begin
      lane_cnt <= '0;
      asm_q    <= '0;
    end else begin
      lane_cnt <= cnt_next;
      asm_q    <= asm_next;
    end
  end

  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == OCC_W'(FIFO_DEPTH));
  assign pop        = !fifo_empty && bus.ready;
  // Full FIFO still accepts when the head leaves in the same cycle.
  assign do_push    = push && (!fifo_full || pop);

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) begin
      mem_word[wr_ptr]  <= asm_next;
      mem_bytes[wr_ptr] <= cnt_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      occ <= occ + OCC_W'(do_push) - OCC_W'(pop);
      if (push && !do_push) begin
        overflow_o <= 1'b1;
      end
    end
  end

  assign bus.word_valid = !fifo_empty;
  assign bus.word       = fifo_empty ? '0 : mem_word[rd_ptr];
  assign bus.bytes      = fifo_empty ? '0 : mem_bytes[rd_ptr];
  assign busy_o         = (lane_cnt != '0) || !fifo_empty;
endmodule
